// File: rtl/mem_arbiter.sv
// mem_arbiter: grants a single four-bank memory port to either the I-side or
// the D-side cache controller. Ownership is held for as long as the owner keeps
// its req high. Strobes, address and write data of the owner are routed to the
// memory combinationally, and the memory's stall and read data are returned to it.
//
// Optional feature: define ARB_ROUND_ROBIN_EN to resolve simultaneous requests
// in favour of the side that did not own memory last. When it is undefined,
// the D side always wins a tie.
//
// Ports
//   clk                 single clock, rising edge
//   rst                 synchronous active-high reset
//   i_req / d_req       requester wants memory (held for the whole line)
//   i_rd, i_wr          I-side read / write strobes
//   d_rd, d_wr          D-side read / write strobes
//   i_addr, i_wdata     I-side address / write data (16 bits)
//   d_addr, d_wdata     D-side address / write data (16 bits)
//   i_gnt / d_gnt       requester owns memory
//   i_rdata / d_rdata   read data to the owner, 0 to the non-owner
//   i_stall / d_stall   requester must hold its strobes
//   mem_addr, mem_wdata address / write data to memory
//   mem_rd, mem_wr      strobes to memory
//   mem_rdata           read data from memory
//   mem_stall           memory busy
//   err                 sticky protocol error flag
//
// state  | meaning
// IDLE   | nobody owns memory, memory strobes are quiet
// OWN_I  | I side owns memory
// OWN_D  | D side owns memory
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic        d_req,
    input  logic        i_rd,
    input  logic        i_wr,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_wdata,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        i_gnt,
    output logic        d_gnt,
    output logic [15:0] i_rdata,
    output logic [15:0] d_rdata,
    output logic        i_stall,
    output logic        d_stall,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_stall,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_I = 2'b01,
        OWN_D = 2'b10
    } state_t;

    state_t state_q;
    state_t state_d;
    state_t tie_win;
    logic   err_q;
    logic   err_d;
    logic   own_i;
    logic   own_d;

    assign own_i = (state_q == OWN_I);
    assign own_d = (state_q == OWN_D);

`ifdef ARB_ROUND_ROBIN_EN
    state_t last_q;

    // Records the side that most recently entered ownership.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= OWN_I;
        end else if ((state_d != IDLE) && (state_d != state_q)) begin
            last_q <= state_d;
        end
    end

    always_comb begin
        tie_win = OWN_D;
        if (last_q == OWN_D) begin
            tie_win = OWN_I;
        end
    end
`else
    assign tie_win = OWN_D;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Hand-over goes straight to the waiting side, without an IDLE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_req && d_req) begin
                    state_d = tie_win;
                end else if (d_req) begin
                    state_d = OWN_D;
                end else if (i_req) begin
                    state_d = OWN_I;
                end
            end
            OWN_I: begin
                if (!i_req) begin
                    if (d_req) state_d = OWN_D;
                    else       state_d = IDLE;
                end
            end
            OWN_D: begin
                if (!d_req) begin
                    if (i_req) state_d = OWN_I;
                    else       state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A waiting non-owner with req high may hold strobes; that is legal.
    always_comb begin
        err_d = err_q
              | (own_i & i_rd & i_wr)
              | (own_d & d_rd & d_wr)
              | (~i_req & (i_rd | i_wr))
              | (~d_req & (d_rd | d_wr));
    end

    always_comb begin
        i_gnt     = own_i;
        d_gnt     = own_d;
        i_rdata   = 16'h0000;
        d_rdata   = 16'h0000;
        i_stall   = 1'b1;
        d_stall   = 1'b1;
        mem_addr  = 16'h0000;
        mem_wdata = 16'h0000;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        if (own_i) begin
            mem_addr  = i_addr;
            mem_wdata = i_wdata;
            mem_rd    = i_rd;
            mem_wr    = i_wr;
            i_stall   = mem_stall;
            i_rdata   = mem_rdata;
        end else if (own_d) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_rd    = d_rd;
            mem_wr    = d_wr;
            d_stall   = mem_stall;
            d_rdata   = mem_rdata;
        end
        // Reset kills the strobes immediately, before the state register clears.
        if (rst) begin
            mem_rd = 1'b0;
            mem_wr = 1'b0;
        end
    end

    assign err = err_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have ports i_req / d_req  input  1 each  I-side / D-side cache controller requests ownership of memory; held high for the whole line transaction.
REQ-004 SHALL have ports i_rd, i_wr / d_rd, d_wr  input  1 each  per-requester memory read / write strobes.
REQ-005 SHALL have ports i_addr, i_wdata / d_addr, d_wdata  input  16 each  per-requester address and write data.
REQ-006 SHALL have ports i_gnt / d_gnt  output  1 each  requester currently owns memory.
REQ-007 SHALL have ports i_rdata / d_rdata  output  16 each  memory read data, routed to owner.
REQ-008 SHALL have ports i_stall / d_stall  output  1 each  requester must hold its strobes.
REQ-009 SHALL have ports mem_addr, mem_wdata  output  16 each  and mem_rd, mem_wr  output  1 each  to four-bank memory.
REQ-010 SHALL have ports mem_rdata  input  16  and mem_stall  input  1  from four-bank memory.
REQ-011 SHALL have port err  output  1  protocol error flag.

Function
REQ-012 SHALL implement states IDLE, OWN_I, OWN_D, state held in a 2-bit register.
REQ-013 IDLE: no grant; on any req, next state = OWN_ of the winner (REQ-016); else stay IDLE.
REQ-014 OWN_X: x_gnt=1; stay while x_req=1; on x_req=0 go to OWN_ of other side if its req=1, else IDLE; no IDLE bubble on switch.
REQ-015 Grants SHALL be decoded from state only; grant latency from req rising in IDLE = 1 cycle.
REQ-016 Winner on simultaneous requests decided per Configuration; single request always wins.
REQ-017 In OWN_X: mem_addr/mem_wdata/mem_rd/mem_wr = X-side inputs combinationally; x_stall = mem_stall; x_rdata = mem_rdata.
REQ-018 Non-owner: stall=1, rdata=0; its rd/wr SHALL NOT reach memory.
REQ-019 IDLE: mem_rd=mem_wr=0, mem_addr=mem_wdata=0, both stalls=1.
REQ-020 Ownership change SHALL NOT occur while owner's req=1, regardless of mem_stall or other side.
REQ-021 err SHALL assert (registered, one cycle later, sticky until reset) when: owner drives rd and wr together, or a requester drives rd/wr with req=0.
REQ-022 Non-owner asserting rd/wr with req=1 is legal (waits) and SHALL NOT set err.

Reset
REQ-023 While rst=1 at a clock edge: state=IDLE, err=0, last-owner register=OWN_I; outputs SHALL take IDLE values (REQ-019) from the following cycle.
REQ-024 rst mid-transaction SHALL abort ownership; mem_rd/mem_wr SHALL be 0 combinationally whenever rst=1.

Configuration
REQ-025 Macro ARB_ROUND_ROBIN_EN SHALL select the tie-break policy.
REQ-026 Defined: on simultaneous requests, grant goes to the side not recorded in last-owner register; last-owner updates on every entry to OWN_I/OWN_D.
REQ-027 Undefined: fixed priority, D side always wins ties; last-owner register absent.

Verification
REQ-028 Reset then i_req=1 only, i_rd=1, i_addr=0x1230 -> i_gnt=1 next cycle, mem_addr=0x1230, mem_rd=1, d_stall=1.
REQ-029 i_req, d_req rise same cycle from IDLE -> d_gnt=1 first (both builds, last-owner=I at reset); D drops req -> i_gnt=1 the following cycle, no IDLE cycle.
REQ-030 ARB_ROUND_ROBIN_EN defined, both sides request continuously with 4-cycle transactions -> grants alternate D,I,D,I; undefined -> I granted only when d_req=0.
REQ-031 D owns, mem_stall=1 for 3 cycles with d_wr=1, d_wdata=0xBEEF -> d_stall follows mem_stall, owner unchanged, mem_wdata=0xBEEF throughout.
REQ-032 Owner drives rd=wr=1 -> err=1 next cycle and stays 1; rst=1 pulse -> err=0, state IDLE, mem_rd=mem_wr=0.
